// File: rtl/apb_ctrl_pkg.sv
// apb_ctrl_pkg: shared types and constants for the two-requester APB master
package apb_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    localparam int   TIMEOUT_DEFAULT = 15;
    localparam logic SLV1 = 1'b0;
    localparam logic SLV2 = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, pointer moves only on an accepted grant
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic last;
    // a lone request wins outright; a tie goes to whoever was not granted last
    always_comb gnt = req == 2'b11 ? (last ? 2'b01 : 2'b10) : req;
    // remember the last winner; reset favours requester 0 on the first tie
    always_ff @(posedge clk) last <= rst ? 1'b1 : (advance && |gnt) ? gnt[1] : last;
endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: arbitrates two requesters onto an APB bus with two slaves and a wait timeout
module apb_master_arb
    import apb_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [1:0]  req_slv,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_grant,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [7:0]  PADDR,
    output logic [7:0]  PWDATA,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic [7:0]  PRDATA1,
    input  logic [7:0]  PRDATA2
);
    state_t     state, nxt;
    logic [1:0] gnt, psel, grant_n, rsp_n, psel_n;
    logic [7:0] cnt, cnt_n, rdata_n, rdata_sel;
    logic       gi, owner, slv, slv_n, ready, tout, done, take, err_n, penable_n;

    rr_arbiter2 u_arb (
        .clk    (PCLK),
        .rst    (PRESET),
        .req    (req_valid),
        .advance(take),
        .gnt    (gnt)
    );

    assign take      = state == IDLE && |req_valid;
    assign gi        = gnt[1];
    assign ready     = slv == SLV2 ? PREADY2 : PREADY1;
    assign rdata_sel = slv == SLV2 ? PRDATA2 : PRDATA1;
    assign tout      = !ready && cnt == 8'(TIMEOUT - 1);
    assign done      = state == ACCESS && (ready || tout);
    assign PSEL1     = psel[0];
    assign PSEL2     = psel[1];

    // state and wait counter
    always_ff @(posedge PCLK) begin
        state <= PRESET ? IDLE : nxt;
        cnt   <= PRESET ? 8'd0 : cnt_n;
    end

    // IDLE -> SETUP on a request, SETUP always one cycle, ACCESS until ready or timeout
    always_comb begin
        nxt = state == IDLE ? (|req_valid ? SETUP : IDLE) :
              state == SETUP ? ACCESS : (done ? IDLE : ACCESS);
    end

    // next values of the registered outputs
    always_comb begin
        slv_n     = state == IDLE ? req_slv[gi] : slv;
        grant_n   = state == IDLE ? gnt : 2'b00;
        rsp_n     = done ? (owner ? 2'b10 : 2'b01) : 2'b00;
        err_n     = done && !ready;
        rdata_n   = done && ready && !PWRITE ? rdata_sel : 8'd0;
        psel_n    = nxt != IDLE ? (slv_n == SLV2 ? 2'b10 : 2'b01) : 2'b00;
        penable_n = nxt == ACCESS;
        cnt_n     = state == ACCESS && !done ? cnt + 8'd1 : 8'd0;
    end

    // output registers and the transfer captured at grant
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            req_grant <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            psel      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            owner     <= 1'b0;
            slv       <= SLV1;
        end else begin
            req_grant <= grant_n;
            rsp_valid <= rsp_n;
            rsp_rdata <= rdata_n;
            rsp_err   <= err_n;
            psel      <= psel_n;
            PENABLE   <= penable_n;
            if (take) begin
                owner  <= gi;
                slv    <= req_slv[gi];
                PWRITE <= req_write[gi];
                PADDR  <= gi ? req_addr[15:8] : req_addr[7:0];
                PWDATA <= gi ? req_wdata[15:8] : req_wdata[7:0];
            end
        end
    end
endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: directed vectors and corner sequences for apb_master_arb
module tb_apb_master_arb;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  req_valid, req_write, req_slv;
    logic [15:0] req_addr, req_wdata;
    logic [1:0]  req_grant, rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err, PSEL1, PSEL2, PENABLE, PWRITE;
    logic [7:0]  PADDR, PWDATA;
    logic        PREADY1;
    logic        PREADY2;
    logic [7:0]  PRDATA1, PRDATA2;
    logic [7:0]  mem1 [256];
    logic [7:0]  mem2 [256];
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] valid;
        logic       wr;
        logic       slv;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       rdy1;
        logic [1:0] grant;
        logic [1:0] rsp;
        logic       err;
        logic [7:0] rdata;
        int         lat;
    } vec_t;

    apb_master_arb #(.TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_slv(req_slv),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY1(PREADY1), .PREADY2(PREADY2), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2)
    );

    always #5 PCLK = ~PCLK;

    assign PREADY2 = 1'b1;
    assign PRDATA1 = mem1[PADDR];
    assign PRDATA2 = mem2[PADDR];

    // simple memory slaves; slave 1 only completes while PREADY1 is high
    always @(posedge PCLK) begin
        if (PSEL1 && PENABLE && PWRITE && PREADY1) mem1[PADDR] <= PWDATA;
        if (PSEL2 && PENABLE && PWRITE) mem2[PADDR] <= PWDATA;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int n;
        logic [1:0] psel;
        psel = v.slv ? 2'b10 : 2'b01;
        PREADY1   = v.rdy1;
        req_valid = v.valid;
        req_write = v.valid[1] ? {v.wr, ~v.wr} : {~v.wr, v.wr};
        req_slv   = v.valid[1] ? {v.slv, ~v.slv} : {~v.slv, v.slv};
        req_addr  = v.valid[1] ? {v.addr, ~v.addr} : {~v.addr, v.addr};
        req_wdata = v.valid[1] ? {v.wdata, ~v.wdata} : {~v.wdata, v.wdata};
        tick();
        chk($sformatf("v%0d_grant", k), req_grant, v.grant);
        chk($sformatf("v%0d_setup_sel", k), {PSEL2, PSEL1, PENABLE}, {psel, 1'b0});
        chk($sformatf("v%0d_setup_bus", k), {PWRITE, PADDR}, {v.wr, v.addr});
        if (v.wr) chk($sformatf("v%0d_pwdata", k), PWDATA, v.wdata);
        req_valid = 2'b00;
        tick();
        chk($sformatf("v%0d_access", k), {PSEL2, PSEL1, PENABLE, req_grant, rsp_valid}, {psel, 1'b1, 4'b0});
        n = 1;
        while (rsp_valid == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("v%0d_rsp", k), {rsp_valid, rsp_err, rsp_rdata}, {v.rsp, v.err, v.rdata});
        chk($sformatf("v%0d_latency", k), n, v.lat);
        chk($sformatf("v%0d_idle_bus", k), {PSEL2, PSEL1, PENABLE, req_grant}, 5'b0);
    endtask

    initial begin
        vec_t vecs [7];
        int gcount, last;
        vecs[0] = '{2'b01, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b1, 2'b01, 2'b01, 1'b0, 8'h00, 2};
        vecs[1] = '{2'b10, 1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 2'b10, 2'b10, 1'b0, 8'hA5, 2};
        vecs[2] = '{2'b10, 1'b1, 1'b0, 8'h20, 8'h3C, 1'b1, 2'b10, 2'b10, 1'b0, 8'h00, 2};
        vecs[3] = '{2'b01, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 2'b01, 2'b01, 1'b0, 8'h3C, 2};
        vecs[4] = '{2'b01, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'h00, 5};
        vecs[5] = '{2'b10, 1'b1, 1'b1, 8'h10, 8'h5A, 1'b1, 2'b10, 2'b10, 1'b0, 8'h00, 2};
        vecs[6] = '{2'b01, 1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 2'b01, 2'b01, 1'b0, 8'h5A, 2};
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 8'h00;
            mem2[i] = 8'h00;
        end
        PRESET = 1'b1;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_slv = 2'b00;
        req_addr = 16'h0;
        req_wdata = 16'h0;
        PREADY1 = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", {req_grant, rsp_valid, rsp_rdata, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA}, 0);
        PRESET = 1'b0;
        tick();
        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        req_valid = 2'b11;
        req_write = 2'b00;
        req_slv = 2'b11;
        req_addr = 16'h1010;
        gcount = 0;
        last = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (req_grant != 2'b00) begin
                if (gcount < 4) begin
                    chk($sformatf("cont_grant%0d", gcount), req_grant, gcount % 2 ? 2'b10 : 2'b01);
                    if (gcount > 0) chk($sformatf("cont_spacing%0d", gcount), c - last, 3);
                end
                last = c;
                gcount++;
            end
        end
        chk("cont_count", gcount, 5);
        req_valid = 2'b00;
        repeat (4) tick();

        PREADY1 = 1'b0;
        req_valid = 2'b10;
        req_slv = 2'b01;
        tick();
        chk("rst_acc_grant", req_grant, 2'b10);
        req_valid = 2'b00;
        tick();
        chk("rst_acc_access", {PSEL2, PSEL1, PENABLE}, 3'b011);
        tick();
        PRESET = 1'b1;
        tick();
        chk("rst_acc_outputs", {req_grant, rsp_valid, rsp_rdata, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA}, 0);
        PRESET = 1'b0;
        gcount = 0;
        repeat (6) begin
            tick();
            if (rsp_valid != 2'b00) gcount++;
        end
        chk("rst_acc_no_rsp", gcount, 0);
        req_valid = 2'b11;
        req_slv = 2'b11;
        tick();
        chk("rst_acc_tie", req_grant, 2'b01);
        req_valid = 2'b00;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
